multicycle_control: RTL and testbench

Main control unit for the multicycle MIPS datapath of project 2. It decodes the 6-bit instruction opcode held in the instruction register and sequences fetch, decode, execute, memory and write-back through a Moore/Mealy FSM. Each cycle it drives the datapath strobes and the 4-bit `ula_operation` code consumed by `ula_control`. It sits between the instruction register and the datapath multiplexers and register enables, and it stalls on a single-bit memory-ready handshake.

---
 rtl/mips_ctrl_pkg.sv | 43 ++++
 rtl/ula_op_encoder.sv | 28 ++
 rtl/multicycle_control.sv | 141 ++++++++++++++
 tb/tb_multicycle_control.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, ULA codes, mux encodings and FSM state types for the multicycle MIPS control unit
package mips_ctrl_pkg;
  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ULA_ADD   = 4'b0000;
  localparam logic [3:0] ULA_SUB   = 4'b0001;
  localparam logic [3:0] ULA_FUNCT = 4'b0010;
  localparam logic [3:0] ULA_SLT   = 4'b0011;
  localparam logic [3:0] ULA_AND   = 4'b0100;
  localparam logic [3:0] ULA_OR    = 4'b0101;
  localparam logic [3:0] ULA_XOR   = 4'b0110;
  localparam logic [3:0] ULA_LUI   = 4'b0111;
  localparam logic [3:0] ULA_SLTU  = 4'b1000;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ULA    = 2'b00;
  localparam logic [1:0] PCS_ULAOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP
  } state_t;

  // What the ULA is doing this cycle, independent of which exact state asked for it
  typedef enum logic [2:0] {C_ADD, C_SUB, C_FUNCT, C_IEXEC, C_IWB} ula_cls_t;
endpackage

// File: rtl/ula_op_encoder.sv
// ula_op_encoder: maps (state class, opcode) to ula_operation and ext_zero
//   i_cls      state class from the FSM
//   i_opcode   IR[31:26]
//   o_ula_op   code to ula_control
//   o_ext_zero zero-extend immediate for logical I-type ops
module ula_op_encoder
  import mips_ctrl_pkg::*;
(
  input  ula_cls_t   i_cls,
  input  logic [5:0] i_opcode,
  output logic [3:0] o_ula_op,
  output logic       o_ext_zero
);
  logic [3:0] w_imm_op;
  logic       w_logical;
  assign w_imm_op = i_opcode == OP_SLTI  ? ULA_SLT  :
                    i_opcode == OP_SLTIU ? ULA_SLTU :
                    i_opcode == OP_ANDI  ? ULA_AND  :
                    i_opcode == OP_ORI   ? ULA_OR   :
                    i_opcode == OP_XORI  ? ULA_XOR  :
                    i_opcode == OP_LUI   ? ULA_LUI  : ULA_ADD;
  assign w_logical = i_opcode == OP_ANDI || i_opcode == OP_ORI || i_opcode == OP_XORI;
  assign o_ula_op = i_cls == C_IEXEC ? w_imm_op  :
                    i_cls == C_FUNCT ? ULA_FUNCT :
                    i_cls == C_SUB   ? ULA_SUB   : ULA_ADD;
  // Held through write-back so the extended immediate stays valid
  assign o_ext_zero = (i_cls == C_IEXEC || i_cls == C_IWB) && w_logical;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main FSM sequencing fetch/decode/execute/memory/write-back of the multicycle MIPS datapath
//   clk, rst_n         clock, async active-low reset
//   opcode, mem_ready  IR opcode and memory handshake
//   remaining outputs  datapath strobes, mux selects, ula_operation, sticky illegal_op
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [3:0] ula_operation,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       ula_src_a,
  output logic [1:0] ula_src_b,
  output logic       ext_zero,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_op
);
  state_t   r_state;
  logic     r_illegal;
  ula_cls_t w_cls;
  logic     w_fetch_go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:     if (mem_ready) r_state <= S_DECODE;
        S_DECODE:
          case (opcode)
            OP_R:                 r_state <= S_R_EXEC;
            OP_LW, OP_SW:         r_state <= S_MEM_ADDR;
            OP_BEQ, OP_BNE:       r_state <= S_BRANCH;
            OP_J:                 r_state <= S_JUMP;
            OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI,
            OP_ORI, OP_XORI, OP_LUI: r_state <= S_I_EXEC;
            default: begin
              r_state   <= S_FETCH;
              r_illegal <= 1'b1;
            end
          endcase
        S_MEM_ADDR:  r_state <= opcode == OP_SW ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  if (mem_ready) r_state <= S_MEM_WB;
        S_MEM_WRITE: if (mem_ready) r_state <= S_FETCH;
        S_R_EXEC:    r_state <= S_R_WB;
        S_I_EXEC:    r_state <= S_I_WB;
        default:     r_state <= S_FETCH;
      endcase
    end
  end

  assign w_cls = r_state == S_R_EXEC ? C_FUNCT :
                 r_state == S_BRANCH ? C_SUB   :
                 r_state == S_I_EXEC ? C_IEXEC :
                 r_state == S_I_WB   ? C_IWB   : C_ADD;

  ula_op_encoder u_enc (
    .i_cls      (w_cls),
    .i_opcode   (opcode),
    .o_ula_op   (ula_operation),
    .o_ext_zero (ext_zero)
  );

  // Mealy fetch strobes: gated by rst_n so nothing fires while reset is held
  assign w_fetch_go = mem_ready && rst_n;
  assign illegal_op = r_illegal;

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = PCS_ULA;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    ula_src_a     = 1'b0;
    ula_src_b     = SRCB_RT;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ula_src_b = SRCB_FOUR;
        ir_write  = w_fetch_go;
        pc_write  = w_fetch_go;
      end
      S_DECODE:    ula_src_b = SRCB_IMM_SH;
      S_MEM_ADDR: begin
        ula_src_a = 1'b1;
        ula_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_R_EXEC:    ula_src_a = 1'b1;
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_I_EXEC: begin
        ula_src_a = 1'b1;
        ula_src_b = SRCB_IMM;
      end
      S_I_WB:      reg_write = 1'b1;
      S_BRANCH: begin
        ula_src_a     = 1'b1;
        pc_write_cond = 1'b1;
        pc_source     = PCS_ULAOUT;
        branch_ne     = opcode == OP_BNE;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCS_JUMP;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed self-checking bench for multicycle_control
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic [3:0] ula_operation;
  logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write;
  logic       ula_src_a, ext_zero, reg_write, reg_dst, mem_to_reg, illegal_op;
  logic [1:0] pc_source, ula_src_b;
  logic [19:0] w_vec;
  logic [19:0] tr [0:19];
  int n;
  int checks = 0;
  int errors = 0;
  logic [19:0] e_fetch_go, e_fetch_wait, e_decode, e_mem_addr, e_mem_read, e_mem_wb, e_mem_write;
  logic [19:0] e_r_exec, e_r_wb, e_ori_exec, e_ori_wb, e_sltiu_exec, e_i_wb, e_addi_exec;
  logic [19:0] e_bne, e_beq, e_jump;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .ula_operation(ula_operation), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .branch_ne(branch_ne), .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .ula_src_a(ula_src_a), .ula_src_b(ula_src_b),
    .ext_zero(ext_zero), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  assign w_vec = {ula_operation, pc_write, pc_write_cond, branch_ne, pc_source, i_or_d, mem_read,
                  mem_write, ir_write, ula_src_a, ula_src_b, ext_zero, reg_write, reg_dst, mem_to_reg};

  function automatic logic [19:0] v(input logic [3:0] op, input logic pcw, pcwc, bne,
                                    input logic [1:0] pcs, input logic iord, mr, mw, irw, sa,
                                    input logic [1:0] sb, input logic ez, rw, rd, m2r);
    return {op, pcw, pcwc, bne, pcs, iord, mr, mw, irw, sa, sb, ez, rw, rd, m2r};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH until the next FETCH, stalling mem_ready
  // for fst FETCH cycles and mst memory-access cycles; records each cycle in tr.
  task automatic run(input logic [5:0] op, input int fst, input int mst);
    int fc = 0;
    int mc = 0;
    bit left = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      opcode = op;
      if (mem_read && !i_or_d) begin
        if (left) break;
        mem_ready = fc >= fst;
        fc++;
      end else begin
        left = 1;
        if (i_or_d) begin
          mem_ready = mc >= mst;
          mc++;
        end else mem_ready = 1'b0;
      end
      #1;
      tr[n] = w_vec;
      n++;
      tick();
    end
  endtask

  initial begin
    e_fetch_go   = v(4'b0000, 1, 0, 0, 2'b00, 0, 1, 0, 1, 0, 2'b01, 0, 0, 0, 0);
    e_fetch_wait = v(4'b0000, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    e_decode     = v(4'b0000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0);
    e_mem_addr   = v(4'b0000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0);
    e_mem_read   = v(4'b0000, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    e_mem_wb     = v(4'b0000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 1);
    e_mem_write  = v(4'b0000, 0, 0, 0, 2'b00, 1, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0);
    e_r_exec     = v(4'b0010, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0);
    e_r_wb       = v(4'b0000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1, 0);
    e_ori_exec   = v(4'b0101, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b10, 1, 0, 0, 0);
    e_ori_wb     = v(4'b0000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0);
    e_sltiu_exec = v(4'b1000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0);
    e_i_wb       = v(4'b0000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0);
    e_addi_exec  = v(4'b0000, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0);
    e_bne        = v(4'b0001, 0, 1, 1, 2'b01, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0);
    e_beq        = v(4'b0001, 0, 1, 0, 2'b01, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0);
    e_jump       = v(4'b0000, 1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);

    rst_n = 1'b0;
    mem_ready = 1'b0;
    opcode = 6'b000000;
    #12;
    check("reset_vec", w_vec, e_fetch_wait);
    check("reset_illegal", illegal_op, 0);
    mem_ready = 1'b1;
    #1;
    check("reset_forces_strobes", w_vec, e_fetch_wait);
    rst_n = 1'b1;
    #1;
    check("post_reset_mealy", w_vec, e_fetch_go);
    mem_ready = 1'b0;
    tick();

    run(6'b000000, 0, 0);
    check("r_cycles", n, 4);
    check("r_fetch", tr[0], e_fetch_go);
    check("r_decode", tr[1], e_decode);
    check("r_exec", tr[2], e_r_exec);
    check("r_wb", tr[3], e_r_wb);

    run(6'b100011, 0, 2);
    check("lw_cycles", n, 7);
    check("lw_addr", tr[2], e_mem_addr);
    check("lw_read0", tr[3], e_mem_read);
    check("lw_read2", tr[5], e_mem_read);
    check("lw_wb", tr[6], e_mem_wb);
    for (int i = 0; i < 6; i++) check($sformatf("lw_m2r_%0d", i), tr[i][0], 0);

    run(6'b101011, 0, 1);
    check("sw_cycles", n, 5);
    check("sw_addr", tr[2], e_mem_addr);
    check("sw_write0", tr[3], e_mem_write);
    check("sw_write1", tr[4], e_mem_write);

    run(6'b001101, 0, 0);
    check("ori_cycles", n, 4);
    check("ori_exec", tr[2], e_ori_exec);
    check("ori_wb", tr[3], e_ori_wb);

    run(6'b001011, 0, 0);
    check("sltiu_cycles", n, 4);
    check("sltiu_exec", tr[2], e_sltiu_exec);
    check("sltiu_wb", tr[3], e_i_wb);

    run(6'b000101, 0, 0);
    check("bne_cycles", n, 3);
    check("bne_branch", tr[2], e_bne);

    run(6'b000100, 0, 0);
    check("beq_cycles", n, 3);
    check("beq_branch", tr[2], e_beq);

    run(6'b000010, 0, 0);
    check("j_cycles", n, 3);
    check("j_jump", tr[2], e_jump);

    run(6'b000000, 2, 0);
    check("stall_cycles", n, 6);
    check("stall_fetch0", tr[0], e_fetch_wait);
    check("stall_fetch1", tr[1], e_fetch_wait);
    check("stall_fetch2", tr[2], e_fetch_go);
    check("stall_decode", tr[3], e_decode);

    check("illegal_before", illegal_op, 0);
    run(6'b111111, 0, 0);
    check("illegal_cycles", n, 2);
    check("illegal_decode", tr[1], e_decode);
    check("illegal_set", illegal_op, 1);
    run(6'b001000, 0, 0);
    check("addi_cycles", n, 4);
    check("addi_exec", tr[2], e_addi_exec);
    check("illegal_sticky", illegal_op, 1);

    opcode = 6'b100011;
    mem_ready = 1'b1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    check("pre_reset_mem_read", w_vec, e_mem_read);
    rst_n = 1'b0;
    #1;
    check("midrd_reset_vec", w_vec, e_fetch_wait);
    check("midrd_reset_illegal", illegal_op, 0);
    #2;
    rst_n = 1'b1;
    tick();
    check("after_reset_hold", w_vec, e_fetch_wait);

    run(6'b000000, 0, 0);
    check("r2_cycles", n, 4);
    check("r2_exec", tr[2], e_r_exec);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
